// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states and
// the load-lane extension helper.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } lsu_state_t;

    // Extend a right-justified lane to 32 bits; word accesses pass through unchanged.
    function automatic logic [31:0] extend(input logic [31:0] lane,
                                           input logic [1:0]  size,
                                           input logic        sgn);
        case (size)
            SZ_BYTE: extend = {{24{sgn & lane[7]}}, lane[7:0]};
            SZ_HALF: extend = {{16{sgn & lane[15]}}, lane[15:0]};
            default: extend = lane;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response handshake of the load/store unit.
// master = CPU datapath, slave = load_store_unit.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_misaligned;
    logic                  resp_range_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_range_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_range_err
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends a load lane from a memory word and
// merges a store lane into a memory word (little-endian byte lanes).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);
    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [31:0] shifted_mask;

    assign shamt = {byte_off_i, 3'b000};

    always_comb begin
        case (size_i)
            SZ_BYTE: lane_mask = 32'h0000_00FF;
            SZ_HALF: lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    end

    assign shifted_mask = lane_mask << shamt;
    assign load_o       = extend(word_i >> shamt, size_i, signed_i);
    assign store_o      = (word_i & ~shifted_mask) | ((wdata_i << shamt) & shifted_mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word CPU requests into word memory accesses,
// using read-modify-write for sub-word stores. Optional macro: LSU_MISALIGN_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    load_store_unit_if.slave      cpu,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           dataWrite,
    output logic                  memWrite,
    output logic                  memRead,
    input  logic [31:0]           dataRead
);
    lsu_state_t            state_q, state_d;
    logic                  write_q, write_d;
    logic                  sgn_q, sgn_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           merge_q, merge_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mis_q, mis_d;
    logic                  rng_q, rng_d;

    logic [1:0]            size_eff;
    logic [1:0]            align_mask;
    logic                  misaligned;
    logic                  out_of_range;
    logic [ADDR_WIDTH-1:0] addr_eff;
    logic [31:0]           load_word;
    logic [31:0]           store_word;

    // Reserved size code 3 behaves as a word access.
    assign size_eff   = (cpu.req_size == 2'd3) ? SZ_WORD : cpu.req_size;
    assign align_mask = (size_eff == SZ_HALF) ? 2'b01 :
                        (size_eff == SZ_WORD) ? 2'b11 : 2'b00;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = |(cpu.req_addr[1:0] & align_mask);
    assign addr_eff   = cpu.req_addr;
`else
    assign misaligned = 1'b0;
    assign addr_eff   = {cpu.req_addr[ADDR_WIDTH-1:2], cpu.req_addr[1:0] & ~align_mask};
`endif

    assign out_of_range = {2'b00, cpu.req_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_WORDS);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        write_d = write_q;
        sgn_d   = sgn_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        rng_d   = rng_q;
        case (state_q)
            IDLE: begin
                if (cpu.req_valid) begin
                    write_d = cpu.req_write;
                    sgn_d   = cpu.req_signed;
                    size_d  = size_eff;
                    addr_d  = addr_eff;
                    wdata_d = cpu.req_wdata;
                    merge_d = '0;
                    rdata_d = '0;
                    mis_d   = misaligned;
                    rng_d   = out_of_range;
                    if (misaligned || out_of_range) state_d = RESP;
                    else if (!cpu.req_write)        state_d = RD;
                    else if (size_eff == SZ_WORD)   state_d = WR;
                    else                            state_d = RMW_RD;
                end
            end
            RD: begin
                rdata_d = load_word;
                state_d = RESP;
            end
            RMW_RD: begin
                merge_d = dataRead;
                state_d = WR;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments; reset is synchronous and clears every register.
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            sgn_q   <= sgn_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            rng_q   <= rng_d;
        end
    end

    // Loads extract from the live memory word; stores merge into the captured word.
    lsu_lane_align u_lane_align (
        .word_i     (write_q ? merge_q : dataRead),
        .byte_off_i (addr_q[1:0]),
        .size_i     (size_q),
        .signed_i   (sgn_q),
        .wdata_i    (wdata_q),
        .load_o     (load_word),
        .store_o    (store_word)
    );

    assign address   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign dataWrite = store_word;
    assign memRead   = (state_q == RD) || (state_q == RMW_RD);
    // Gated so a reset arriving during WR cannot commit a partial store.
    assign memWrite  = (state_q == WR) && !reset;

    assign cpu.req_ready       = (state_q == IDLE);
    assign cpu.resp_valid      = (state_q == RESP);
    assign cpu.resp_rdata      = rdata_q;
    assign cpu.resp_misaligned = mis_q;
    assign cpu.resp_range_err  = rng_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset-abort
// sequence and randomized requests against a byte-level reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int AW = 32;
    localparam int MW = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic [31:0]   dataWrite;
    logic [31:0]   dataRead;
    logic          memWrite;
    logic          memRead;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(AW)) cpu ();

    load_store_unit #(.ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu.slave),
        .address   (address),
        .dataWrite (dataWrite),
        .memWrite  (memWrite),
        .memRead   (memRead),
        .dataRead  (dataRead)
    );

    // Data memory: combinational read, write on posedge, plus a preload port.
    logic [31:0] mem [MW];
    logic        bk_we = 1'b0;
    logic [7:0]  bk_idx = '0;
    logic [31:0] bk_data = '0;

    assign dataRead = (address[AW-1:10] == '0) ? mem[address[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (bk_we)                                  mem[bk_idx] <= bk_data;
        else if (memWrite && address[AW-1:10] == '0) mem[address[9:2]] <= dataWrite;
    end

    // Reference memory image and counters.
    logic [31:0] ref_mem [MW];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: byte-by-byte access to the memory image.
    task automatic model_access(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] ad, input logic [31:0] wd,
                                output logic [31:0] rd, output logic mis,
                                output logic rng, output int lat);
        int     nb;
        int     off;
        int     idx;
        longint val;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(ad[1:0]);
        idx = int'(ad[31:2]);
        mis = (off % nb) != 0;
`ifndef LSU_MISALIGN_CHECK_EN
        off = off - (off % nb);
        mis = 1'b0;
`endif
        rng = (ad[31:2] >= 30'(MW));
        rd  = '0;
        if (mis || rng) begin
            lat = 1;
        end else if (wr) begin
            for (int i = 0; i < nb; i++) ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
            lat = (nb == 4) ? 2 : 3;
        end else begin
            val = 0;
            for (int i = 0; i < nb; i++) val += longint'(ref_mem[idx][8*(off+i) +: 8]) << (8*i);
            if (sg && nb < 4 && val >= (longint'(1) << (8*nb-1))) val -= longint'(1) << (8*nb);
            rd  = 32'(val);
            lat = 2;
        end
    endtask

    // Issue one request and observe it until resp_valid (bounded).
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata,
                          output logic mis, output logic rng,
                          output int n_rd, output int n_wr,
                          output logic [31:0] last_dw, output logic [31:0] last_wa);
        int both;
        lat = 0; rdata = '0; mis = 1'b0; rng = 1'b0;
        n_rd = 0; n_wr = 0; both = 0; last_dw = '0; last_wa = '0;
        @(negedge clk);
        check("req_ready_idle", 32'(cpu.req_ready), 32'd1);
        cpu.req_valid  = 1'b1;
        cpu.req_write  = wr;
        cpu.req_size   = sz;
        cpu.req_signed = sg;
        cpu.req_addr   = ad;
        cpu.req_wdata  = wd;
        @(posedge clk);
        #1;
        cpu.req_valid  = 1'b0;
        cpu.req_write  = 1'($urandom);
        cpu.req_size   = 2'($urandom);
        cpu.req_addr   = $urandom;
        cpu.req_wdata  = $urandom;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (memRead) n_rd++;
            if (memWrite) begin
                n_wr++;
                last_dw = dataWrite;
                last_wa = address;
            end
            if (memRead && memWrite) both++;
            if (cpu.resp_valid) begin
                lat   = k;
                rdata = cpu.resp_rdata;
                mis   = cpu.resp_misaligned;
                rng   = cpu.resp_range_err;
                break;
            end
        end
        if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
        check("strobe_exclusive", 32'(both), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_rng;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_dw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic wr, input logic [1:0] sz,
                                input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                                input logic [31:0] er, input logic em, input logic eg,
                                input int el, input int erd, input int ewr,
                                input logic [31:0] edw);
        vec_t v;
        v.name = name; v.wr = wr; v.sz = sz; v.sg = sg; v.ad = ad; v.wd = wd;
        v.exp_rdata = er; v.exp_mis = em; v.exp_rng = eg; v.exp_lat = el;
        v.exp_rd = erd; v.exp_wr = ewr; v.exp_dw = edw;
        return v;
    endfunction

    initial begin
        int          lat, n_rd, n_wr, m_lat;
        logic [31:0] rdata, dw, wa, m_rd;
        logic        mis, rng, m_mis, m_rng;
        logic        wr, sg;
        logic [1:0]  sz;
        logic [31:0] ad, wd;

        cpu.req_valid = 1'b0; cpu.req_write = 1'b0; cpu.req_size = 2'd0;
        cpu.req_signed = 1'b0; cpu.req_addr = '0; cpu.req_wdata = '0;
        reset = 1'b1;

        for (int i = 0; i < MW; i++) ref_mem[i] = $urandom;
        ref_mem[4]   = 32'h8899_AABB;
        ref_mem[255] = 32'h1122_3344;
        for (int i = 0; i < MW; i++) begin
            @(negedge clk);
            bk_we = 1'b1; bk_idx = 8'(i); bk_data = ref_mem[i];
        end
        @(negedge clk);
        bk_we = 1'b0;

        check("rst_req_ready",  32'(cpu.req_ready),  32'd1);
        check("rst_resp_valid", 32'(cpu.resp_valid), 32'd0);
        check("rst_resp_rdata", cpu.resp_rdata,      32'd0);
        check("rst_mem_strobe", 32'({memRead, memWrite}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cpu.req_ready), 32'd1);

        vecs.push_back(mk("lb_11",  0, 2'd0, 1, 32'h11, 0, 32'hFFFF_FFAA, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk("lbu_11", 0, 2'd0, 0, 32'h11, 0, 32'h0000_00AA, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk("lh_12",  0, 2'd1, 1, 32'h12, 0, 32'hFFFF_8899, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk("lhu_10", 0, 2'd1, 0, 32'h10, 0, 32'h0000_AABB, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk("sb_13",  1, 2'd0, 0, 32'h13, 32'h55, 0, 0, 0, 3, 1, 1, 32'h5599_AABB));
        vecs.push_back(mk("lw_10",  0, 2'd2, 0, 32'h10, 0, 32'h5599_AABB, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk("sw_20",  1, 2'd2, 0, 32'h20, 32'hDEAD_BEEF, 0, 0, 0, 2, 0, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk("lw_20",  0, 2'd2, 1, 32'h20, 0, 32'hDEAD_BEEF, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk("lw_400", 0, 2'd2, 0, 32'h400, 0, 0, 0, 1, 1, 0, 0, 0));
`ifdef LSU_MISALIGN_CHECK_EN
        vecs.push_back(mk("lw_22",  0, 2'd2, 0, 32'h22, 0, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("lhu_13", 0, 2'd1, 0, 32'h13, 0, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("sh_401", 1, 2'd1, 0, 32'h401, 32'h1, 0, 1, 1, 1, 0, 0, 0));
`else
        vecs.push_back(mk("lw_22",  0, 2'd2, 0, 32'h22, 0, 32'hDEAD_BEEF, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk("lhu_13", 0, 2'd1, 0, 32'h13, 0, 32'h0000_5599, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk("sh_401", 1, 2'd1, 0, 32'h401, 32'h1, 0, 0, 1, 1, 0, 0, 0));
`endif
        vecs.push_back(mk("sh_3fe", 1, 2'd1, 0, 32'h3FE, 32'h8001, 0, 0, 0, 3, 1, 1, 32'h8001_3344));
        vecs.push_back(mk("lh_3fe", 0, 2'd1, 1, 32'h3FE, 0, 32'hFFFF_8001, 0, 0, 2, 1, 0, 0));
        vecs.push_back(mk("lw_rsv", 0, 2'd3, 0, 32'h20, 0, 32'hDEAD_BEEF, 0, 0, 2, 1, 0, 0));

        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].ad, vecs[i].wd,
                   lat, rdata, mis, rng, n_rd, n_wr, dw, wa);
            check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            check({vecs[i].name, "_mis"},   32'(mis), 32'(vecs[i].exp_mis));
            check({vecs[i].name, "_rng"},   32'(rng), 32'(vecs[i].exp_rng));
            check({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_nrd"},   32'(n_rd), 32'(vecs[i].exp_rd));
            check({vecs[i].name, "_nwr"},   32'(n_wr), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr != 0) begin
                check({vecs[i].name, "_dw"}, dw, vecs[i].exp_dw);
                check({vecs[i].name, "_wa"}, wa, {vecs[i].ad[31:2], 2'b00});
            end
            model_access(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].ad, vecs[i].wd,
                         m_rd, m_mis, m_rng, m_lat);
        end

        // Reset during the WR cycle of a halfword store aborts it cleanly.
        @(negedge clk);
        cpu.req_valid = 1'b1; cpu.req_write = 1'b1; cpu.req_size = 2'd1;
        cpu.req_signed = 1'b0; cpu.req_addr = 32'h12; cpu.req_wdata = 32'h7777;
        @(posedge clk);
        #1 cpu.req_valid = 1'b0;
        @(negedge clk);
        check("abort_rmw_read", 32'(memRead), 32'd1);
        @(negedge clk);
        check("abort_wr_cycle", 32'(memWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_wr_gated", 32'(memWrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready",     32'(cpu.req_ready),  32'd1);
        check("abort_no_resp",   32'(cpu.resp_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_quiet", 32'({cpu.resp_valid, memRead, memWrite}), 32'd0);
        end
        check("abort_mem_kept", mem[4], ref_mem[4]);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rdata, mis, rng, n_rd, n_wr, dw, wa);
        check("abort_lw_10", rdata, 32'h5599_AABB);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 300; t++) begin
            wr = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            if ($urandom_range(0, 9) == 0) ad = {2'b00, 30'($urandom_range(250, 300))} << 0;
            else                           ad = {2'b00, 30'($urandom_range(0, 15))};
            ad = {ad[29:0], 2'($urandom)};
            wd = $urandom;
            model_access(wr, sz, sg, ad, wd, m_rd, m_mis, m_rng, m_lat);
            do_req(wr, sz, sg, ad, wd, lat, rdata, mis, rng, n_rd, n_wr, dw, wa);
            check("rnd_rdata", rdata, m_rd);
            check("rnd_mis",   32'(mis), 32'(m_mis));
            check("rnd_rng",   32'(rng), 32'(m_rng));
            check("rnd_lat",   32'(lat), 32'(m_lat));
            check("rnd_nwr",   32'(n_wr), 32'(wr && !m_mis && !m_rng));
        end

        @(negedge clk);
        for (int i = 0; i < 16; i++)   check("mem_image_lo", mem[i], ref_mem[i]);
        for (int i = 250; i < MW; i++) check("mem_image_hi", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
